// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Opcode/funct/ALU encodings follow the classic MIPS subset (lw, sw, R-type, beq, addi, j).
package mc_controller_pkg;

    typedef logic       u1;
    typedef logic [1:0] u2;
    typedef logic [2:0] u3;
    typedef logic [3:0] u4;
    typedef logic [5:0] u6;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALUCTL_W = 3;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam u6 OP_RTYPE = 6'h00;
    localparam u6 OP_J     = 6'h02;
    localparam u6 OP_BEQ   = 6'h04;
    localparam u6 OP_ADDI  = 6'h08;
    localparam u6 OP_LW    = 6'h23;
    localparam u6 OP_SW    = 6'h2B;

    localparam u6 FUNCT_ADD = 6'h20;
    localparam u6 FUNCT_SUB = 6'h22;
    localparam u6 FUNCT_AND = 6'h24;
    localparam u6 FUNCT_OR  = 6'h25;
    localparam u6 FUNCT_SLT = 6'h2A;

    localparam u3 ALU_AND = 3'b000;
    localparam u3 ALU_OR  = 3'b001;
    localparam u3 ALU_ADD = 3'b010;
    localparam u3 ALU_SUB = 3'b110;
    localparam u3 ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    // Moore control word produced from the current state alone.
    typedef struct packed {
        u1      pcwrite;
        u1      branch;
        u1      irwrite;
        u1      memwrite;
        u1      iord;
        u1      regwrite;
        u1      regdst;
        u1      memtoreg;
        u1      alusrca;
        u2      alusrcb;
        u2      pcsrc;
        aluop_t aluop;
    } ctrl_t;

    function automatic u1 op_known(input u6 op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_known = 1'b1;
            default:                                       op_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller-to-datapath/memory bundle: instruction fields and zero flag in, control strobes out.
interface mc_controller_if;
    import mc_controller_pkg::*;

    u6 op;
    u6 funct;
    u1 zero;

    u1 pcen;
    u1 memwrite;
    u1 irwrite;
    u1 iord;
    u1 regwrite;
    u1 regdst;
    u1 memtoreg;
    u1 alusrca;
    u2 alusrcb;
    u2 pcsrc;
    u3 alucontrol;
    u1 illegal;
    u4 state;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, iord, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, iord, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, state
    );

endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU decoder: maps aluop/funct to the 3-bit ALU control and flags supported R-type functs.
module mc_controller_alu_decoder
    import mc_controller_pkg::*;
(
    input  aluop_t i_aluop,
    input  u6      i_funct,
    output u3      o_alucontrol,
    output u1      o_funct_ok
);

    u3 w_funct_ctl;

    // funct lookup; unsupported functs fall back to add so the write still completes
    always_comb begin
        w_funct_ctl = ALU_ADD;
        o_funct_ok  = 1'b1;
        case (i_funct)
            FUNCT_ADD: w_funct_ctl = ALU_ADD;
            FUNCT_SUB: w_funct_ctl = ALU_SUB;
            FUNCT_AND: w_funct_ctl = ALU_AND;
            FUNCT_OR:  w_funct_ctl = ALU_OR;
            FUNCT_SLT: w_funct_ctl = ALU_SLT;
            default: begin
                w_funct_ctl = ALU_ADD;
                o_funct_ok  = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD:   o_alucontrol = ALU_ADD;
            ALUOP_SUB:   o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: o_alucontrol = w_funct_ctl;
            default:     o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM; all strobes derive from the current state except the ALU decode.
// Write/enable strobes are suppressed combinationally while reset is held.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    u3      w_alucontrol;
    u1      w_funct_ok;
    u1      w_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH: w_next_state = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_RTYPE:     w_next_state = RTYPEEX;
                    OP_BEQ:       w_next_state = BEQEX;
                    OP_ADDI:      w_next_state = ADDIEX;
                    OP_J:         w_next_state = JEX;
                    default:      w_next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW) begin
                    w_next_state = MEMRD;
                end else if (bus.op == OP_SW) begin
                    w_next_state = MEMWR;
                end else begin
                    w_next_state = FETCH;
                end
            end
            MEMRD:   w_next_state = MEMWB;
            RTYPEEX: w_next_state = RTYPEWB;
            ADDIEX:  w_next_state = ADDIWB;
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            FETCH: begin
                w_ctrl.irwrite = 1'b1;
                w_ctrl.pcwrite = 1'b1;
                w_ctrl.alusrcb = 2'b01;
            end
            DECODE: w_ctrl.alusrcb = 2'b11;
            MEMADR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = 2'b10;
            end
            MEMRD: w_ctrl.iord = 1'b1;
            MEMWB: begin
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                w_ctrl.regdst   = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.aluop   = ALUOP_SUB;
                w_ctrl.pcsrc   = 2'b01;
                w_ctrl.branch  = 1'b1;
            end
            ADDIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = 2'b10;
            end
            ADDIWB: w_ctrl.regwrite = 1'b1;
            JEX: begin
                w_ctrl.pcsrc   = 2'b10;
                w_ctrl.pcwrite = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    mc_controller_alu_decoder u_alu_decoder (
        .i_aluop      (w_ctrl.aluop),
        .i_funct      (bus.funct),
        .o_alucontrol (w_alucontrol),
        .o_funct_ok   (w_funct_ok)
    );

    // funct_ok is aluop-independent, so it can be judged in DECODE before RTYPEEX
    assign w_illegal = TRAP_ILLEGAL && (r_state == DECODE) &&
                       (!op_known(bus.op) || ((bus.op == OP_RTYPE) && !w_funct_ok));

    assign bus.pcen       = ~reset & (w_ctrl.pcwrite | (w_ctrl.branch & bus.zero));
    assign bus.irwrite    = ~reset & w_ctrl.irwrite;
    assign bus.memwrite   = ~reset & w_ctrl.memwrite;
    assign bus.regwrite   = ~reset & w_ctrl.regwrite;
    assign bus.illegal    = ~reset & w_illegal;
    assign bus.iord       = w_ctrl.iord;
    assign bus.regdst     = w_ctrl.regdst;
    assign bus.memtoreg   = w_ctrl.memtoreg;
    assign bus.alusrca    = w_ctrl.alusrca;
    assign bus.alusrcb    = w_ctrl.alusrcb;
    assign bus.pcsrc      = w_ctrl.pcsrc;
    assign bus.alucontrol = w_alucontrol;
    assign bus.state      = u4'(r_state);

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS main control FSM plus ALU decoder. Sits directly upstream of the unified instruction/data memory.
- Drives the memory's iord, irwrite and we, and the datapath muxes and enables.
- Consumes the opcode/funct of the latched instruction and the ALU zero flag.
- Moore-style: every control output is a pure function of the current state; the ALU decode is the only exception.

Parameters:
TRAP_ILLEGAL, 1, 1: unknown opcode/funct pulses illegal for one cycle; 0: illegal is tied low (decode still returns to FETCH).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0]
zero  input  1  ALU zero flag
pcen  output  1  PC register enable = pcwrite | (branch & zero)
memwrite  output  1  memory we
irwrite  output  1  memory irwrite
iord  output  1  memory iord (0=pc, 1=dataaddr)
regwrite  output  1  register file write enable
regdst  output  1  0=rt, 1=rd
memtoreg  output  1  0=ALUOut, 1=readdata
alusrca  output  1  0=PC, 1=A
alusrcb  output  2  00=B, 01=4, 10=signimm, 11=signimm<<2
pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  output  1  one-cycle pulse in DECODE on unsupported op/funct
state  output  4  current state, for debug

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 23h/2Bh->MEMADR, 00h->RTYPEEX, 04h->BEQEX, 08h->ADDIEX, 02h->JEX, other->FETCH.
  - MEMADR: 23h->MEMRD, 2Bh->MEMWR.
  - MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Per-state outputs (unlisted signals are 0; aluop is the internal 2-bit decode input):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- ALU decode:
  - aluop 00->010, 01->110.
  - aluop 10 by funct: 20h->010, 22h->110, 24h->000, 25h->001, 2Ah->111.
  - Other funct: alucontrol=010, and in RTYPEEX the write still completes (treated as add). The funct illegal pulse is raised in DECODE when op=00h and funct is unsupported.
- Memory timing contract:
  - Memory reads are registered. instr is captured at the posedge ending FETCH (irwrite=1, iord=0).
  - readdata is captured at the posedge ending MEMRD and is consumed in MEMWB.
  - Writes commit at the posedge ending MEMWR.
- Reset:
  - Sampled on posedge; state<=FETCH. FETCH is therefore the state in the first cycle after reset deassertion.
  - While reset=1, pcen, pcwrite, irwrite, memwrite, regwrite and illegal are forced to 0 combinationally. Other outputs follow the state.
  - Reset in any state (e.g. mid MEMRD/MEMWR) aborts the instruction; no regwrite/memwrite occurs afterwards for it.
- op/funct are only examined in DECODE, MEMADR (op) and RTYPEEX (funct). The IR is stable there because irwrite=1 only in FETCH.
- beq with zero=0: pcen=0 in BEQEX and the PC keeps PC+4 from FETCH.
- illegal is high only during the DECODE cycle, never for two consecutive cycles.

Decomposition:
- Shared package (common.svh): u1/u2/u3/u4/u6 typedefs.
- Also in the package: a state_t enum (4 bits, FETCH=0); opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J; funct constants; ALU control constants; aluop_t.
- One sub-module: alu_decoder (aluop, funct -> alucontrol, funct_ok). mc_controller holds the FSM.

Test Plan:
- Reset held 2 cycles, then op=23h (lw): states 0->1->2->3->4->0. irwrite=1 only in cycle 0, iord=1 in MEMRD, regwrite=1 and memtoreg=1 only in MEMWB.
- op=2Bh (sw): FETCH, DECODE, MEMADR, MEMWR. memwrite=1 and iord=1 exactly one cycle, regwrite never 1.
- op=00h, funct=22h: RTYPEEX alucontrol=110, alusrca=1, alusrcb=00. RTYPEWB regdst=1, regwrite=1. Repeat funct=2Ah -> 111.
- op=04h: with zero=1, BEQEX pcen=1 and pcsrc=01. With zero=0, pcen=0. op=02h: JEX pcsrc=10, pcen=1, total 3 cycles.
- op=3Fh: illegal=1 for exactly the DECODE cycle, next state FETCH. With TRAP_ILLEGAL=0, illegal stays 0.
- lw with reset asserted during MEMRD: next state FETCH, memwrite/regwrite stay 0 through the reset cycle and the following FETCH's predecessor cycle.
